cacheline_adaptor: RTL

- Sits directly downstream of the cache datapath's physical-memory side.
- Converts the cache's single 256-bit line transfer into a burst of four 64-bit beats on the physical memory bus.
- Covers both line fill (read) and writeback (write).
- Presents a single-pulse line response back to the cache controller.

---
 rtl/cacheline_adaptor_pkg.sv | 17 +
 rtl/cacheline_beat_ctr.sv | 25 ++
 rtl/cacheline_adaptor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int S_OFFSET   = 5;
    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int NUM_BEATS  = 4;

    // Adaptor transaction phases: waiting, fill burst, writeback burst, line response.
    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_beat_ctr.sv
// Two-bit beat counter: selects which 64-bit slice of the line is on the bus.
// It wraps 3 -> 0 on the final beat, so a completed burst leaves it at zero.
module cacheline_beat_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] count,
    output logic       last_beat
);

    // Count accepted beats; synchronous clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
        end else if (clr) begin
            count <= 2'd0;
        end else if (en) begin
            count <= count + 2'd1;
        end
    end

    assign last_beat = (count == 2'd3);

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line transfer into four 64-bit memory beats,
// for both line fills (read) and writebacks (write), with a one-cycle
// line response back to the cache controller.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,

    input  logic [BEAT_WIDTH-1:0] burst_i,
    output logic [BEAT_WIDTH-1:0] burst_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    adaptor_state_t state, next_state;

    logic [31:0]           addr_reg;
    logic [LINE_WIDTH-1:0] wr_buf;
    // Only the first three beats need holding; the fourth goes straight into line_o.
    logic [3*BEAT_WIDTH-1:0] fill_buf;

    logic [1:0] beat_cnt;
    logic       last_beat;
    logic       in_burst;
    logic       beat_en;
    logic       accept;

    assign in_burst = (state == RD_BURST) || (state == WR_BURST);
    assign beat_en  = in_burst && resp_i;
    assign accept   = (state == IDLE) && (read_i || write_i);

    cacheline_beat_ctr u_beat_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == DONE),
        .en        (beat_en),
        .count     (beat_cnt),
        .last_beat (last_beat)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a writeback wins over a fill when both are requested.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (write_i) begin
                    next_state = WR_BURST;
                end else if (read_i) begin
                    next_state = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (resp_i && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch request data at acceptance and assemble fill beats; line_o only changes when a fill completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            wr_buf   <= '0;
            fill_buf <= '0;
            line_o   <= '0;
        end else begin
            if (accept) begin
                addr_reg <= address_i & 32'hFFFF_FFE0;
            end
            if ((state == IDLE) && write_i) begin
                wr_buf <= line_i;
            end
            if ((state == RD_BURST) && resp_i) begin
                case (beat_cnt)
                    2'd0:    fill_buf[63:0]    <= burst_i;
                    2'd1:    fill_buf[127:64]  <= burst_i;
                    2'd2:    fill_buf[191:128] <= burst_i;
                    default: line_o            <= {burst_i, fill_buf};
                endcase
            end
        end
    end

    // Output decode: bus strobes and line response from state, write data muxed by beat.
    always_comb begin
        read_o  = (state == RD_BURST);
        write_o = (state == WR_BURST);
        resp_o  = (state == DONE);
        burst_o = '0;
        if (state == WR_BURST) begin
            case (beat_cnt)
                2'd0:    burst_o = wr_buf[63:0];
                2'd1:    burst_o = wr_buf[127:64];
                2'd2:    burst_o = wr_buf[191:128];
                default: burst_o = wr_buf[255:192];
            endcase
        end
    end

    assign address_o = addr_reg;

endmodule
